// File: rtl/conv_pool_sched.sv
// conv_pool_sched: counted FSM that walks every 2x2 window of a conv (stride 1) or pool (stride 2) pass.
// Latency: RD0 one cycle after start; 7+OP_LAT cycles per window; done one cycle after the last write.
// Backpressure: none; the memory and datapath are assumed always ready. start/mode are ignored unless IDLE.
// Ports: clk/rst (sync, active-low) | start, mode -> busy, done handshake |
//        read, write, addr -> pixel memory | load, conv_en, pool_en, c_p -> datapath | row, col -> position.
// Limits: ADDR_W <= 16 is not required (address math is done at ADDR_W); OP_LAT must be 1..256.
module conv_pool_sched #(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int ADDR_W   = 8,
  parameter int OUT_BASE = 64,
  parameter int OP_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        load,
  output logic              conv_en,
  output logic              pool_en,
  output logic              c_p,
  output logic [3:0]        row,
  output logic [3:0]        col
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_LD, S_EXEC, S_WAIT, S_WR, S_DONE
  } state_t;

  localparam logic [3:0] CONV_W   = 4'(IMG_W - 1);
  localparam logic [3:0] CONV_H   = 4'(IMG_H - 1);
  localparam logic [3:0] POOL_W   = 4'(IMG_W / 2);
  localparam logic [3:0] POOL_H   = 4'(IMG_H / 2);
  localparam logic [7:0] LAT_LAST = 8'(OP_LAT - 1);

  state_t            state, state_nxt;
  logic              mode_q;
  logic [7:0]        out_idx;
  logic [7:0]        wait_cnt;
  logic [3:0]        out_w, out_h;
  logic              last_col, last_win, wait_done;
  logic [ADDR_W-1:0] r_org, c_org, base, wr_addr;

  assign out_w     = mode_q ? POOL_W : CONV_W;
  assign out_h     = mode_q ? POOL_H : CONV_H;
  assign last_col  = (col == out_w - 4'd1);
  assign last_win  = last_col && (row == out_h - 4'd1);
  assign wait_done = (wait_cnt == LAT_LAST);

  // Pool windows start at even coordinates; arithmetic wraps at ADDR_W bits on purpose.
  assign r_org   = mode_q ? ADDR_W'({row, 1'b0}) : ADDR_W'(row);
  assign c_org   = mode_q ? ADDR_W'({col, 1'b0}) : ADDR_W'(col);
  assign base    = r_org * ADDR_W'(IMG_W) + c_org;
  assign wr_addr = ADDR_W'(OUT_BASE) + ADDR_W'(out_idx);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RD0;
      S_RD0:  state_nxt = S_RD1;
      S_RD1:  state_nxt = S_RD2;
      S_RD2:  state_nxt = S_RD3;
      S_RD3:  state_nxt = S_LD;
      S_LD:   state_nxt = S_EXEC;
      S_EXEC: state_nxt = S_WAIT;
      S_WAIT: if (wait_done) state_nxt = S_WR;
      S_WR:   state_nxt = last_win ? S_DONE : S_RD0;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      mode_q   <= 1'b0;
      row      <= 4'd0;
      col      <= 4'd0;
      out_idx  <= 8'd0;
      wait_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (start) begin
          mode_q  <= mode;
          row     <= 4'd0;
          col     <= 4'd0;
          out_idx <= 8'd0;
        end
        S_EXEC: wait_cnt <= 8'd0;
        S_WAIT: wait_cnt <= wait_cnt + 8'd1;
        S_WR: begin
          out_idx <= out_idx + 8'd1;
          if (last_col) begin
            col <= 4'd0;
            row <= row + 4'd1;
          end else begin
            col <= col + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode the registered state only. Each load strobe lags its read by
  // one cycle because memory data lands on din the cycle after read.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    addr    = '0;
    load    = 4'b0000;
    conv_en = 1'b0;
    pool_en = 1'b0;
    c_p     = 1'b0;
    case (state)
      S_RD0: begin busy = 1'b1; read = 1'b1; addr = base; end
      S_RD1: begin busy = 1'b1; read = 1'b1; addr = base + ADDR_W'(1); load = 4'b1000; end
      S_RD2: begin busy = 1'b1; read = 1'b1; addr = base + ADDR_W'(IMG_W); load = 4'b0100; end
      S_RD3: begin busy = 1'b1; read = 1'b1; addr = base + ADDR_W'(IMG_W + 1); load = 4'b0010; end
      S_LD:   begin busy = 1'b1; load = 4'b0001; end
      S_EXEC: begin busy = 1'b1; conv_en = ~mode_q; pool_en = mode_q; end
      S_WAIT: busy = 1'b1;
      S_WR:   begin busy = 1'b1; write = 1'b1; addr = wr_addr; c_p = mode_q; end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_pool_sched.sv
// tb_conv_pool_sched: directed bench for conv_pool_sched.
// Two instances: u_d4 (4x4, OP_LAT=1) and u_d5 (5x5, OP_LAT=2) share clock and reset.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_conv_pool_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start4 = 1'b0, mode4 = 1'b0, start5 = 1'b0, mode5 = 1'b0;

  logic       bz4, dn4, rd4, wr4, ce4, pe4, cp4;
  logic [7:0] a4;
  logic [3:0] ld4, row4, col4;
  logic       bz5, dn5, rd5, wr5, ce5, pe5, cp5;
  logic [7:0] a5;
  logic [3:0] ld5, row5, col5;

  always #5 clk = ~clk;

  conv_pool_sched #(.IMG_W(4), .IMG_H(4), .ADDR_W(8), .OUT_BASE(64), .OP_LAT(1)) u_d4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4), .busy(bz4), .done(dn4),
    .read(rd4), .write(wr4), .addr(a4), .load(ld4), .conv_en(ce4), .pool_en(pe4),
    .c_p(cp4), .row(row4), .col(col4));

  conv_pool_sched #(.IMG_W(5), .IMG_H(5), .ADDR_W(8), .OUT_BASE(64), .OP_LAT(2)) u_d5 (
    .clk(clk), .rst(rst), .start(start5), .mode(mode5), .busy(bz5), .done(dn5),
    .read(rd5), .write(wr5), .addr(a5), .load(ld5), .conv_en(ce5), .pool_en(pe5),
    .c_p(cp5), .row(row5), .col(col5));

  int checks = 0;
  int errors = 0;

  // Hand-derived read orders.
  int exp_c4_last [4]  = '{10, 11, 14, 15};
  int exp_p4 [16] = '{0,1,4,5, 2,3,6,7, 8,9,12,13, 10,11,14,15};
  int exp_p5 [16] = '{0,1,5,6, 2,3,7,8, 10,11,15,16, 12,13,17,18};

  // Observation state filled by run_watch.
  logic       s_rd, s_wr, s_dn, s_ce, s_pe, s_cp, s_bz;
  logic [7:0] s_a;
  logic [3:0] s_ld, s_row, s_col;
  logic [7:0] rdq[$];
  int         rcyc[$];
  logic [7:0] wrq[$];
  int         wcyc[$];
  logic       wcp[$];
  logic [3:0] wrow[$], wcol[$];
  logic [3:0] ld_hist [16];
  logic [3:0] r0, c0;
  int         done_cyc, first_en;
  logic       rw_both, both_en, saw_conv, saw_pool;
  int         ncp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic samp(input int w);
    if (w == 0) begin
      s_rd = rd4; s_wr = wr4; s_dn = dn4; s_ce = ce4; s_pe = pe4; s_cp = cp4; s_bz = bz4;
      s_a = a4; s_ld = ld4; s_row = row4; s_col = col4;
    end else begin
      s_rd = rd5; s_wr = wr5; s_dn = dn5; s_ce = ce5; s_pe = pe5; s_cp = cp5; s_bz = bz5;
      s_a = a5; s_ld = ld5; s_row = row5; s_col = col5;
    end
  endtask

  function automatic logic [31:0] rq(input int i);
    return (i < rdq.size()) ? 32'(rdq[i]) : 'x;
  endfunction
  function automatic logic [31:0] wq(input int i);
    return (i < wrq.size()) ? 32'(wrq[i]) : 'x;
  endfunction

  // Called with the DUT already in RD0 (cycle 0). Returns positioned on the done cycle.
  // inj >= 0 pulses start=1/mode=1 on instance u_d4 during that cycle.
  task automatic run_watch(input int w, input int inj, input int budget);
    rdq.delete(); rcyc.delete(); wrq.delete(); wcyc.delete(); wcp.delete();
    wrow.delete(); wcol.delete();
    for (int i = 0; i < 16; i++) ld_hist[i] = 4'hf;
    done_cyc = -1; first_en = -1; ncp = 0;
    rw_both = 1'b0; both_en = 1'b0; saw_conv = 1'b0; saw_pool = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      samp(w);
      if (cyc < 16) ld_hist[cyc] = s_ld;
      if (cyc == 0) begin r0 = s_row; c0 = s_col; end
      if (s_rd) begin rdq.push_back(s_a); rcyc.push_back(cyc); end
      if (s_wr) begin
        wrq.push_back(s_a); wcyc.push_back(cyc); wcp.push_back(s_cp);
        wrow.push_back(s_row); wcol.push_back(s_col);
        if (s_cp) ncp++;
      end
      if (s_rd && s_wr) rw_both = 1'b1;
      if (s_ce && s_pe) both_en = 1'b1;
      if (s_ce) saw_conv = 1'b1;
      if (s_pe) saw_pool = 1'b1;
      if ((s_ce || s_pe) && first_en < 0) first_en = cyc;
      if (s_dn) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == inj) begin start4 = 1'b1; mode4 = 1'b1; end
      tick();
      if (cyc == inj) begin start4 = 1'b0; mode4 = 1'b0; end
    end
  endtask

  task automatic chk_idle4(input string tag);
    chk({tag, " busy"}, 32'(bz4), 0);
    chk({tag, " rd/wr/done"}, {29'd0, rd4, wr4, dn4}, 0);
    chk({tag, " addr"}, 32'(a4), 0);
    chk({tag, " load"}, 32'(ld4), 0);
    chk({tag, " en/cp"}, {29'd0, ce4, pe4, cp4}, 0);
    chk({tag, " row/col"}, {24'd0, row4, col4}, 0);
  endtask

  initial begin
    int quiet;

    // Reset from power-up.
    repeat (3) tick();
    chk_idle4("rst0");
    chk("rst0 d5 busy", {30'd0, bz5, rd5}, 0);
    rst = 1'b1;
    tick();

    // Conv 4x4 with an ignored pool start at cycle 10.
    start4 = 1'b1; mode4 = 1'b0;
    tick();
    start4 = 1'b0;
    run_watch(0, 10, 200);
    chk("conv start row/col", {24'd0, r0, c0}, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("conv w0 rd%0d", i), rq(i), (i < 2) ? i : i + 2);
      chk($sformatf("conv w0 rdcyc%0d", i), (i < rcyc.size()) ? rcyc[i] : -1, i);
    end
    chk("conv load c0", 32'(ld_hist[0]), 0);
    chk("conv load c1", 32'(ld_hist[1]), 8);
    chk("conv load c2", 32'(ld_hist[2]), 4);
    chk("conv load c3", 32'(ld_hist[3]), 2);
    chk("conv load c4", 32'(ld_hist[4]), 1);
    chk("conv load c5", 32'(ld_hist[5]), 0);
    chk("conv en cycle", first_en, 5);
    chk("conv no pool_en", 32'(saw_pool), 0);
    chk("conv reads", rdq.size(), 36);
    for (int i = 0; i < 4; i++) chk($sformatf("conv last rd%0d", i), rq(32 + i), exp_c4_last[i]);
    chk("conv writes", wrq.size(), 9);
    chk("conv wr0 cycle", (wcyc.size() > 0) ? wcyc[0] : -1, 7);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("conv wr%0d addr", i), wq(i), 64 + i);
      chk($sformatf("conv wr%0d row/col", i),
          (i < wrow.size()) ? {24'd0, wrow[i], wcol[i]} : 'x, {24'd0, 4'(i / 3), 4'(i % 3)});
    end
    chk("conv c_p", ncp, 0);
    chk("conv done cycle", done_cyc, 72);
    chk("conv rd&wr", 32'(rw_both), 0);
    chk("conv both en", 32'(both_en), 0);
    chk("conv done busy", 32'(bz4), 0);

    // start during DONE is ignored; start on the following IDLE cycle launches a pool run.
    start4 = 1'b1; mode4 = 1'b1;
    tick();
    chk("after done busy/read/done", {29'd0, bz4, rd4, dn4}, 0);
    tick();
    start4 = 1'b0; mode4 = 1'b0;
    run_watch(0, -1, 200);
    chk("pool4 start rd", {31'd0, s_rd}, 0);
    chk("pool4 reads", rdq.size(), 16);
    for (int i = 0; i < 16; i++) chk($sformatf("pool4 rd%0d", i), rq(i), exp_p4[i]);
    chk("pool4 writes", wrq.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("pool4 wr%0d addr", i), wq(i), 64 + i);
    chk("pool4 c_p count", ncp, 4);
    chk("pool4 no conv_en", 32'(saw_conv), 0);
    chk("pool4 en cycle", first_en, 5);
    chk("pool4 done cycle", done_cyc, 32);
    tick();

    // Odd 5x5 pool, OP_LAT=2.
    start5 = 1'b1; mode5 = 1'b1;
    tick();
    start5 = 1'b0; mode5 = 1'b0;
    run_watch(1, -1, 200);
    chk("pool5 reads", rdq.size(), 16);
    for (int i = 0; i < 16; i++) chk($sformatf("pool5 rd%0d", i), rq(i), exp_p5[i]);
    chk("pool5 writes", wrq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pool5 wr%0d addr", i), wq(i), 64 + i);
      chk($sformatf("pool5 wr%0d cycle", i), (i < wcyc.size()) ? wcyc[i] : -1, 8 + 9 * i);
    end
    chk("pool5 c_p count", ncp, 4);
    chk("pool5 done cycle", done_cyc, 36);
    tick();

    // Reset in the WAIT cycle of window 3 (cycle 30 of a 4x4 conv run).
    start4 = 1'b1; mode4 = 1'b0;
    tick();
    start4 = 1'b0;
    repeat (30) tick();
    chk("midrst wait busy", 32'(bz4), 1);
    chk("midrst wait strobes", {28'd0, rd4, wr4, ce4, pe4}, 0);
    chk("midrst wait row/col", {24'd0, row4, col4}, {24'd0, 4'd1, 4'd0});
    rst = 1'b0;
    tick();
    chk_idle4("midrst asserted");
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk_idle4("midrst released");
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      if (rd4 || wr4 || bz4) quiet++;
      tick();
    end
    chk("post-reset activity", quiet, 0);
    start4 = 1'b1; mode4 = 1'b0;
    tick();
    start4 = 1'b0;
    run_watch(0, -1, 200);
    chk("restart row/col", {24'd0, r0, c0}, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("restart rd%0d", i), rq(i), (i < 2) ? i : i + 2);
    chk("restart writes", wrq.size(), 9);
    chk("restart wr0 addr", wq(0), 64);
    chk("restart done cycle", done_cyc, 72);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
